// File: rtl/csi_rx_raw10_depack_pkg.sv
`default_nettype none
// ============================================================================
// Module : csi_rx_raw10_depack_pkg
// Brief  : RAW10 pixel/group types and the 5-byte group unpack helper.
// Rev    : 1.0  initial release
// ============================================================================
package csi_rx_raw10_depack_pkg;

  localparam int RAW10_GRP_BYTES = 5;
  localparam int RAW10_PIX_W     = 10;

  typedef logic [RAW10_PIX_W-1:0]          raw10_pix_t;
  typedef raw10_pix_t [1:0]                raw10_pair_t;
  typedef raw10_pix_t [3:0]                raw10_quad_t;
  typedef logic [RAW10_GRP_BYTES-1:0][7:0] raw10_grp_t;

  // Bytes 0..3 carry the pixel MSBs, byte 4 packs the four 2-bit LSB fields.
  function automatic raw10_quad_t raw10_unpack(input raw10_grp_t grp);
    raw10_quad_t q;
    q[0] = {grp[0], grp[4][1:0]};
    q[1] = {grp[1], grp[4][3:2]};
    q[2] = {grp[2], grp[4][5:4]};
    q[3] = {grp[3], grp[4][7:6]};
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi_rx_raw10_stats.sv
`default_nettype none
// ============================================================================
// Module : csi_rx_raw10_stats
// Brief  : Saturating pixels-per-line and lines-per-frame counters.
// Rev    : 1.0  initial release
// ============================================================================
module csi_rx_raw10_stats #(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_vld,
  input  logic             line_act,
  input  logic             frame_act,
  output logic [CNT_W-1:0] stat_line_pix,
  output logic [CNT_W-1:0] stat_frm_lines
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic             r_line_q;
  logic             r_frame_q;
  logic             w_line_fall;
  logic             w_frame_fall;

  assign w_line_fall  = r_line_q && !line_act;
  assign w_frame_fall = r_frame_q && !frame_act;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pix_cnt      <= '0;
      r_line_cnt     <= '0;
      r_line_q       <= 1'b0;
      r_frame_q      <= 1'b0;
      stat_line_pix  <= '0;
      stat_frm_lines <= '0;
    end else begin
      r_line_q  <= line_act;
      r_frame_q <= frame_act;

      if (w_line_fall) begin
        stat_line_pix <= r_pix_cnt;
        r_pix_cnt     <= '0;
      end else if (line_act && pix_vld) begin
        // Two pixels per beat: saturate before the +2 can wrap.
        if (r_pix_cnt >= c_cnt_max - CNT_W'(1))
          r_pix_cnt <= c_cnt_max;
        else
          r_pix_cnt <= r_pix_cnt + CNT_W'(2);
      end

      if (w_frame_fall) begin
        stat_frm_lines <= r_line_cnt;
        r_line_cnt     <= '0;
      end else if (w_line_fall && frame_act && (r_line_cnt != c_cnt_max)) begin
        r_line_cnt <= r_line_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/csi_rx_raw10_depack.sv
`default_nettype none
// ============================================================================
// Module : csi_rx_raw10_depack
// Brief  : CSI-2 RAW10 byte-stream to 2-pixel/cycle depacker with aligned
//          line/frame flags. Define CSI_RAW10_STATS_EN for line/frame stats.
// Rev    : 1.0  initial release
// ============================================================================
module csi_rx_raw10_depack
  import csi_rx_raw10_depack_pkg::*;
#(
  parameter int OUT_DLY = 3,
  parameter int CNT_W   = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      in_dat,
  input  logic             in_vld,
  input  logic             in_line,
  input  logic             in_frame,
  output logic [19:0]      out_pix,
  output logic             out_vld,
  output logic             out_line,
  output logic             out_frame,
  output logic             err_partial,
  output logic [CNT_W-1:0] stat_line_pix,
  output logic [CNT_W-1:0] stat_frm_lines
);

  raw10_grp_t         r_acc;
  logic [2:0]         r_cnt;
  logic               r_line_d;
  raw10_pair_t        r_hold;
  logic               r_hold_vld;
  logic [OUT_DLY-1:0] r_line_sr;
  logic [OUT_DLY-1:0] r_frame_sr;

  logic        w_rise;
  logic        w_fall;
  logic        w_take;
  logic        w_done;
  logic [2:0]  w_base;
  logic [2:0]  w_cnt_nxt;
  raw10_grp_t  w_grp;
  raw10_grp_t  w_acc_nxt;
  raw10_quad_t w_quad;

  always_comb begin
    w_rise    = in_line && !r_line_d;
    w_fall    = !in_line && r_line_d;
    w_take    = in_vld && in_line && enable;
    w_base    = w_rise ? 3'd0 : r_cnt;
    w_grp     = r_acc;
    w_done    = 1'b0;
    w_cnt_nxt = w_base;
    if (w_take) begin
      case (w_base)
        3'd3: begin
          w_grp[3]  = in_dat[7:0];
          w_grp[4]  = in_dat[15:8];
          w_done    = 1'b1;
          w_cnt_nxt = 3'd0;
        end
        3'd4: begin
          w_grp[4]  = in_dat[7:0];
          w_done    = 1'b1;
          w_cnt_nxt = 3'd1;
        end
        default: begin
          w_grp[w_base]        = in_dat[7:0];
          w_grp[w_base + 3'd1] = in_dat[15:8];
          w_cnt_nxt            = w_base + 3'd2;
        end
      endcase
    end
    // The 6th byte of a group-completing beat starts the next group.
    w_acc_nxt = w_grp;
    if (w_take && (w_base == 3'd4))
      w_acc_nxt[0] = in_dat[15:8];
    w_quad = raw10_unpack(w_grp);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc       <= '0;
      r_cnt       <= 3'd0;
      r_line_d    <= 1'b0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_line_sr   <= '0;
      r_frame_sr  <= '0;
      out_pix     <= '0;
      out_vld     <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      r_line_d   <= in_line;
      r_line_sr  <= {r_line_sr[OUT_DLY-2:0], in_line};
      r_frame_sr <= {r_frame_sr[OUT_DLY-2:0], in_frame};

      if (!enable) begin
        r_acc       <= '0;
        r_cnt       <= 3'd0;
        r_hold      <= '0;
        r_hold_vld  <= 1'b0;
        out_pix     <= '0;
        out_vld     <= 1'b0;
        err_partial <= 1'b0;
      end else begin
        r_acc       <= w_acc_nxt;
        r_cnt       <= w_fall ? 3'd0 : w_cnt_nxt;
        err_partial <= w_fall && (r_cnt != 3'd0);
        // Groups complete at least 2 cycles apart, so the hold never collides.
        if (w_done) begin
          out_pix    <= {w_quad[1], w_quad[0]};
          out_vld    <= 1'b1;
          r_hold     <= {w_quad[3], w_quad[2]};
          r_hold_vld <= 1'b1;
        end else if (r_hold_vld) begin
          out_pix    <= r_hold;
          out_vld    <= 1'b1;
          r_hold_vld <= 1'b0;
        end else begin
          out_pix    <= '0;
          out_vld    <= 1'b0;
        end
      end
    end
  end

  assign out_line  = r_line_sr[OUT_DLY-1];
  assign out_frame = r_frame_sr[OUT_DLY-1];

`ifdef CSI_RAW10_STATS_EN
  csi_rx_raw10_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clock          (clock),
    .reset          (reset),
    .pix_vld        (out_vld),
    .line_act       (out_line),
    .frame_act      (out_frame),
    .stat_line_pix  (stat_line_pix),
    .stat_frm_lines (stat_frm_lines)
  );
`else
  assign stat_line_pix  = '0;
  assign stat_frm_lines = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_raw10_depack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_csi_rx_raw10_depack
// Brief  : Directed bench with a cycle-scheduled byte-group model and
//          literal pins; stats checks are active under CSI_RAW10_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_csi_rx_raw10_depack;
  import csi_rx_raw10_depack_pkg::*;

  localparam int OUT_DLY = 3;
  localparam int CNT_W   = 12;
  localparam int NCYC    = 16384;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [15:0]      in_dat;
  logic             in_vld;
  logic             in_line;
  logic             in_frame;
  logic [19:0]      out_pix;
  logic             out_vld;
  logic             out_line;
  logic             out_frame;
  logic             err_partial;
  logic [CNT_W-1:0] stat_line_pix;
  logic [CNT_W-1:0] stat_frm_lines;

  always #5 clock = ~clock;

  csi_rx_raw10_depack #(.OUT_DLY(OUT_DLY), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .in_dat         (in_dat),
    .in_vld         (in_vld),
    .in_line        (in_line),
    .in_frame       (in_frame),
    .out_pix        (out_pix),
    .out_vld        (out_vld),
    .out_line       (out_line),
    .out_frame      (out_frame),
    .err_partial    (err_partial),
    .stat_line_pix  (stat_line_pix),
    .stat_frm_lines (stat_frm_lines)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Expected outputs indexed by the cycle in which they must be visible.
  logic        exp_vld  [NCYC];
  logic [19:0] exp_pix  [NCYC];
  logic        exp_err  [NCYC];
  logic        exp_line [NCYC];
  logic        exp_frm  [NCYC];

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_vld[i] = 1'b0; exp_pix[i] = '0; exp_err[i] = 1'b0;
      exp_line[i] = 1'b0; exp_frm[i] = 1'b0;
    end
  end

  logic [7:0] mbuf[$];
  raw10_pix_t mdl_log[$];
  logic       m_prev_line = 1'b0;

  task automatic push_byte(input logic [7:0] b, input int n);
    mbuf.push_back(b);
    if (mbuf.size() == 5) begin
      raw10_pix_t p [4];
      for (int k = 0; k < 4; k++) begin
        p[k] = raw10_pix_t'(mbuf[k]) * 10'd4 + raw10_pix_t'((mbuf[4] >> (2 * k)) & 8'h03);
        mdl_log.push_back(p[k]);
      end
      exp_vld[n+1] = 1'b1; exp_pix[n+1] = {p[1], p[0]};
      exp_vld[n+2] = 1'b1; exp_pix[n+2] = {p[3], p[2]};
      mbuf.delete();
    end
  endtask

  // Model: inputs of cycle n decide outputs of cycles n+1.. (n+OUT_DLY for flags).
  always @(negedge clock) begin : model
    int n;
    n = cyc;
    if (n + OUT_DLY + 1 < NCYC) begin
      if (!reset || !enable) begin
        mbuf.delete();
        for (int k = n + 1; k <= n + 3; k++) begin
          exp_vld[k] = 1'b0; exp_pix[k] = '0; exp_err[k] = 1'b0;
        end
      end else begin
        if (!in_line && m_prev_line && mbuf.size() != 0) exp_err[n+1] = 1'b1;
        if (!in_line || !m_prev_line) mbuf.delete();
        if (in_line && in_vld) begin
          push_byte(in_dat[7:0], n);
          push_byte(in_dat[15:8], n);
        end
      end
      if (!reset) begin
        for (int k = n + 1; k <= n + OUT_DLY; k++) begin
          exp_line[k] = 1'b0; exp_frm[k] = 1'b0;
        end
      end else begin
        exp_line[n+OUT_DLY] = in_line;
        exp_frm[n+OUT_DLY]  = in_frame;
      end
    end
    m_prev_line = reset ? in_line : 1'b0;
  end

  raw10_pix_t obs_log[$];
  int         obs_err_cnt  = 0;
  int         first_vld    = -1;
  int         last_err_cyc = -1;

  always @(negedge clock) begin : compare
    int m;
    m = cyc;
    if (m >= 1 && m < NCYC) begin
      check("out_vld", out_vld, exp_vld[m]);
      if (exp_vld[m]) check("out_pix", out_pix, exp_pix[m]);
      check("err_partial", err_partial, exp_err[m]);
      check("out_line", out_line, exp_line[m]);
      check("out_frame", out_frame, exp_frm[m]);
      check("vld_outside_line", out_vld && !out_line, 1'b0);
`ifndef CSI_RAW10_STATS_EN
      check("stat_line_pix_tied", stat_line_pix, '0);
      check("stat_frm_lines_tied", stat_frm_lines, '0);
`endif
      if (out_vld) begin
        obs_log.push_back(out_pix[9:0]);
        obs_log.push_back(out_pix[19:10]);
        if (first_vld < 0) first_vld = m;
      end
      if (err_partial) begin
        obs_err_cnt++;
        last_err_cyc = m;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    in_dat = '0;
    repeat (n) step();
  endtask

  task automatic clear_obs();
    obs_log.delete();
    mdl_log.delete();
    obs_err_cnt  = 0;
    first_vld    = -1;
    last_err_cyc = -1;
  endtask

  logic [7:0] lbytes[$];
  int         t_start;
  int         t_fall;

  // One beat per cycle (or every other cycle if gapped); enable drops for drop_beat.
  task automatic send_line(input bit gapped, input int drop_beat);
    int nb;
    nb      = (lbytes.size() + 1) / 2;
    t_start = cyc;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] lo, hi;
      lo      = lbytes[2*b];
      hi      = (2 * b + 1 < lbytes.size()) ? lbytes[2*b+1] : 8'h00;
      in_line = 1'b1;
      in_vld  = 1'b1;
      in_dat  = {hi, lo};
      enable  = (b != drop_beat);
      step();
      if (gapped) begin
        in_vld = 1'b0;
        in_dat = '0;
        step();
      end
    end
    in_line = 1'b0;
    in_vld  = 1'b0;
    in_dat  = '0;
    enable  = 1'b1;
    t_fall  = cyc;
    step();
  endtask

  initial begin
    raw10_pix_t t1_exp [8];
    raw10_pix_t t4_exp [4];
    t1_exp = '{10'h004, 10'h009, 10'h00E, 10'h013, 10'h017, 10'h01A, 10'h01D, 10'h020};
    t4_exp = '{10'h043, 10'h082, 10'h0C1, 10'h100};

    // Reset with busy inputs: every output must still read 0.
    reset = 1'b0; enable = 1'b1; in_line = 1'b1; in_vld = 1'b1;
    in_frame = 1'b1; in_dat = 16'hFFFF;
    repeat (3) step();
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_pix", out_pix, '0);
    check("rst_out_line", out_line, 1'b0);
    check("rst_out_frame", out_frame, 1'b0);
    check("rst_err", err_partial, 1'b0);
    check("rst_stat_pix", stat_line_pix, '0);
    check("rst_stat_lines", stat_frm_lines, '0);
    reset = 1'b1; in_line = 1'b0; in_vld = 1'b0; in_dat = '0;
    idle(6);

    // Two groups, one beat per cycle.
    clear_obs();
    lbytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hE4, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1B};
    send_line(1'b0, -1);
    idle(8);
    check("t1_latency", first_vld, t_start + 3);
    check("t1_obs_count", obs_log.size(), 8);
    check("t1_mdl_count", mdl_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_log.size()) check("t1_obs_pix", obs_log[i], t1_exp[i]);
      if (i < mdl_log.size()) check("t1_mdl_pix", mdl_log[i], t1_exp[i]);
    end
    check("t1_err", obs_err_cnt, 0);

    // Same line, beats every other cycle.
    clear_obs();
    send_line(1'b1, -1);
    idle(8);
    check("t2_obs_count", obs_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < obs_log.size()) check("t2_obs_pix", obs_log[i], t1_exp[i]);
    check("t2_err", obs_err_cnt, 0);

    // 12-byte line: two leftover bytes are dropped with an error pulse.
    clear_obs();
    lbytes.delete();
    for (int i = 0; i < 12; i++) lbytes.push_back(8'(8'h30 + i));
    send_line(1'b0, -1);
    idle(8);
    check("t3_obs_count", obs_log.size(), 8);
    check("t3_err_count", obs_err_cnt, 1);
    check("t3_err_cycle", last_err_cyc, t_fall + 1);

    // Reset mid-group, then a fresh line.
    clear_obs();
    in_line = 1'b1; in_vld = 1'b1; in_dat = 16'hA2A1;
    step();
    in_dat = 16'hA4A3;
    step();
    reset = 1'b0; in_vld = 1'b0; in_dat = '0;
    step();
    check("t4_rst_vld", out_vld, 1'b0);
    check("t4_rst_line", out_line, 1'b0);
    check("t4_rst_pix", out_pix, '0);
    step();
    reset = 1'b1; in_line = 1'b0;
    idle(4);
    lbytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h1B};
    send_line(1'b0, -1);
    idle(8);
    check("t4_obs_count", obs_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_log.size()) check("t4_obs_pix", obs_log[i], t4_exp[i]);

    // Back-to-back lines with a single idle cycle between them.
    clear_obs();
    lbytes.delete();
    for (int i = 0; i < 10; i++) lbytes.push_back(8'(8'h50 + 7 * i));
    send_line(1'b0, -1);
    send_line(1'b0, -1);
    idle(8);
    check("t5_obs_count", obs_log.size(), 16);
    check("t5_err", obs_err_cnt, 0);

    // enable low on the second beat discards the accumulator mid-line.
    clear_obs();
    lbytes.delete();
    for (int i = 0; i < 10; i++) lbytes.push_back(8'(8'h70 + i));
    send_line(1'b0, 1);
    idle(8);
    check("ten_obs_count", obs_log.size(), 4);
    check("ten_err_count", obs_err_cnt, 1);

    // Frame of three 1920-pixel lines.
    clear_obs();
    in_frame = 1'b0;
    idle(8);
    in_frame = 1'b1;
    idle(2);
    lbytes.delete();
    for (int i = 0; i < 2400; i++) lbytes.push_back(8'(i * 13));
    for (int l = 0; l < 3; l++) begin
      send_line(1'b0, -1);
      idle(6);
`ifdef CSI_RAW10_STATS_EN
      check("t6_stat_line_pix", stat_line_pix, 1920);
`endif
    end
    idle(2);
    in_frame = 1'b0;
    idle(OUT_DLY + 4);
`ifdef CSI_RAW10_STATS_EN
    check("t6_stat_frm_lines", stat_frm_lines, 3);
`endif
    check("t6_obs_count", obs_log.size(), 5760);
    check("t6_err", obs_err_cnt, 0);

    check("cycle_budget", cyc < NCYC - 8, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
